gcd_dispatch: RTL
=================

GCD_DISPATCH -- requirements
Module: gcd_dispatch

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries, power of two, >=2.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum WAIT cycles before abort.
REQ-004 SHALL have port clk_i  in  1  single clock, rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports req_valid_i in 1, req_ready_o out 1, req_a_i in WIDTH, req_b_i in WIDTH: upstream operand-pair stream.
REQ-007 SHALL have ports core_start_o out 1, core_a_o out WIDTH, core_b_o out WIDTH: operands and start towards the GCD core.
REQ-008 SHALL have ports core_ready_i in 1 (core idle), core_done_i in 1 (one-cycle completion pulse), core_res_i in WIDTH (result, valid while core_done_i=1).
REQ-009 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1, rsp_res_o out WIDTH, rsp_err_o out 1: downstream result stream.

Function
REQ-010 SHALL transfer on req and rsp channels when valid and ready are both 1 at a rising edge.
REQ-011 SHALL hold one request in a holding register; req_ready_o = holding register empty.
REQ-012 SHALL implement FSM IDLE, ISSUE, WAIT.
REQ-013 IDLE->ISSUE when holding register full, core_ready_i=1 and FIFO count < FIFO_DEPTH; otherwise stay in IDLE.
REQ-014 ISSUE SHALL drive core_start_o=1 for exactly one cycle with core_a_o/core_b_o = held operands, free the holding register, go to WAIT.
REQ-015 core_a_o/core_b_o SHALL remain stable from ISSUE until WAIT exits; core_start_o SHALL be 0 in every other state.
REQ-016 WAIT SHALL, on core_done_i=1, push {err=0, res=core_res_i} into the FIFO and go to IDLE.
REQ-017 SHALL allow at most one outstanding core operation; a push SHALL therefore never meet a full FIFO.
REQ-018 core_done_i outside WAIT SHALL be ignored.
REQ-019 Operands of zero SHALL be forwarded unchanged; the result is whatever the core returns.
REQ-020 A request SHALL be accepted in the same cycle the holding register is freed by ISSUE only on the following cycle (no same-cycle refill); minimum issue interval is 3 cycles plus core latency.
REQ-021 FIFO SHALL be first-in first-out; rsp_valid_o = FIFO not empty; rsp_res_o/rsp_err_o = head entry, stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; pop of an empty FIFO SHALL not occur; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-023 Reset SHALL force state IDLE, holding register empty, FIFO empty, timeout counter 0.
REQ-024 Reset values: req_ready_o=1, core_start_o=0, core_a_o=0, core_b_o=0, rsp_valid_o=0, rsp_res_o=0, rsp_err_o=0.
REQ-025 Reset during ISSUE or WAIT SHALL discard the in-flight operation and all buffered results; no result SHALL appear for it.

Configuration
REQ-026 Macro GCD_DISPATCH_TIMEOUT_EN: when defined, a counter SHALL clear on WAIT entry, increment each WAIT cycle, and at TIMEOUT_CYCLES without core_done_i push {err=1, res=0} and go to IDLE.
REQ-027 Without GCD_DISPATCH_TIMEOUT_EN, no counter SHALL be built, WAIT SHALL persist until core_done_i, and rsp_err_o SHALL be constant 0.

Structure
REQ-028 SHALL place the FSM state enum and the {err,res} FIFO entry struct typedef in shared package gcd_pkg.
REQ-029 SHALL instantiate the result FIFO as sub-module gcd_rsp_fifo (parameters WIDTH, FIFO_DEPTH; push/pop/full/empty/count).

Verification
REQ-030 Request (48,18), rsp_ready_i=1 -> core_start_o one pulse with 48/18; rsp_res_o=6, rsp_err_o=0.
REQ-031 Back-to-back requests (12,8),(17,5),(0,7) -> responses 4,1,7 in order, one core_start_o each.
REQ-032 rsp_ready_i=0, 5 requests, FIFO_DEPTH=4 -> 4 results buffered, 5th not issued (core_start_o=0) until one pop, then issued.
REQ-033 Macro defined, TIMEOUT_CYCLES=16, core stub never pulses done -> after 16 WAIT cycles rsp_err_o=1, rsp_res_o=0, FSM IDLE.
REQ-034 rst_i asserted mid-WAIT then core_done_i pulse -> no response, all outputs at reset values, next request (9,6) returns 3.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types for the GCD dispatcher: FSM state encoding and result FIFO entry.
package gcd_pkg;

  // Widest operand the dispatcher may be built for; narrower builds zero-extend.
  localparam int GCD_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } gcd_state_t;

  typedef struct packed {
    logic                 err;
    logic [GCD_MAX_W-1:0] res;
  } gcd_rsp_t;

endpackage

// File: rtl/gcd_rsp_fifo.sv
// Result FIFO for gcd_dispatch: power-of-two depth, wrapping pointers, explicit count.
module gcd_rsp_fifo
  import gcd_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push_i,
  input  gcd_rsp_t                    push_data_i,
  input  logic                        pop_i,
  output gcd_rsp_t                    pop_data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage keeps only WIDTH result bits plus the error flag.
  logic [WIDTH:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH:0]     w_head_raw;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop_i)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (push_i && !pop_i)      r_count <= r_count + CNT_W'(1);
      else if (pop_i && !push_i) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= {push_data_i.err, WIDTH'(push_data_i.res)};
  end

  assign w_head_raw     = r_mem[r_rd_ptr];
  assign pop_data_o.err = w_head_raw[WIDTH];
  assign pop_data_o.res = GCD_MAX_W'(w_head_raw[WIDTH-1:0]);
  assign full_o         = (r_count == CNT_W'(FIFO_DEPTH));
  assign empty_o        = (r_count == '0);
  assign count_o        = r_count;

endmodule

// File: rtl/gcd_dispatch.sv
// Dispatcher between an operand stream, a single GCD core and a buffered result stream.
// Optional WAIT-state abort counter is enabled with macro GCD_DISPATCH_TIMEOUT_EN.
module gcd_dispatch
  import gcd_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  output logic             core_start_o,
  output logic [WIDTH-1:0] core_a_o,
  output logic [WIDTH-1:0] core_b_o,
  input  logic             core_ready_i,
  input  logic             core_done_i,
  input  logic [WIDTH-1:0] core_res_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_res_o,
  output logic             rsp_err_o
);

  gcd_state_t       r_state, w_state_nxt;
  logic             r_hold_vld;
  logic [WIDTH-1:0] r_hold_a, r_hold_b;
  logic [WIDTH-1:0] r_core_a, r_core_b;
  logic             w_push, w_pop, w_full, w_empty;
  gcd_rsp_t         w_push_data, w_head;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  // Holding register: refilled only once ISSUE has cleared it on a previous edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                          r_hold_vld <= 1'b0;
    else if (r_state == ST_ISSUE)       r_hold_vld <= 1'b0;
    else if (req_valid_i && !r_hold_vld) r_hold_vld <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (req_valid_i && !r_hold_vld) begin
      r_hold_a <= req_a_i;
      r_hold_b <= req_b_i;
    end
  end

  // Core operands latch on the way into ISSUE and hold through WAIT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_core_a <= '0;
      r_core_b <= '0;
    end else if (r_state == ST_IDLE && w_state_nxt == ST_ISSUE) begin
      r_core_a <= r_hold_a;
      r_core_b <= r_hold_b;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

`ifdef GCD_DISPATCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                    r_to_cnt <= '0;
    else if (r_state == ST_ISSUE) r_to_cnt <= '0;
    else if (r_state == ST_WAIT)  r_to_cnt <= r_to_cnt + TO_W'(1);
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_data = '0;
    core_start_o = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_hold_vld && core_ready_i && !w_full) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        core_start_o = 1'b1;
        w_state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done_i) begin
          w_push          = 1'b1;
          w_push_data.res = GCD_MAX_W'(core_res_i);
          w_state_nxt     = ST_IDLE;
        end
`ifdef GCD_DISPATCH_TIMEOUT_EN
        else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_push          = 1'b1;
          w_push_data.err = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  gcd_rsp_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (w_pop),
    .pop_data_o  (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (w_count)
  );

  assign w_pop       = !w_empty && rsp_ready_i;
  assign req_ready_o = !r_hold_vld;
  assign core_a_o    = r_core_a;
  assign core_b_o    = r_core_b;
  assign rsp_valid_o = !w_empty;
  assign rsp_res_o   = w_empty ? '0 : WIDTH'(w_head.res);

`ifdef GCD_DISPATCH_TIMEOUT_EN
  assign rsp_err_o = w_head.err && !w_empty;
`else
  assign rsp_err_o = 1'b0;
`endif

endmodule
